sqrt_seq: RTL

SQRT_SEQ -- requirements
Module: sqrt_seq

---
 rtl/sqrt_seq.sv | 113 +++++++++++
 1 files changed

// File: rtl/sqrt_seq.sv
// Sequential restoring square root: one root bit per CALC cycle, QW CALC cycles per result.
// done pulses QW+1 cycles after start; start is only honoured while ready (IDLE).
module sqrt_seq #(
  parameter int DW = 16,
  localparam int QW = DW / 2,
  localparam int RW = QW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] D,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] Q,
  output logic [RW-1:0] remainder
);

  localparam int CW = (QW > 1) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] op;
  logic [QW-1:0] root;
  logic [QW+1:0] rem;
  logic [CW-1:0] cnt;

  logic [QW+1:0] rem_sh;
  logic [QW+1:0] trial;
  logic [QW+1:0] rem_nxt;
  logic [QW-1:0] root_nxt;
  logic          ge;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring step: bring down the next radicand digit pair, try subtracting 4*root+1.
  always_comb begin
    rem_sh   = (rem << 2) | {{QW{1'b0}}, op[DW-1:DW-2]};
    trial    = {root, 2'b01};
    ge       = (rem_sh >= trial);
    rem_nxt  = ge ? (rem_sh - trial) : rem_sh;
    root_nxt = {root[QW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op        <= '0;
      root      <= '0;
      rem       <= '0;
      cnt       <= '0;
      Q         <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op   <= D;
            root <= '0;
            rem  <= '0;
            cnt  <= CW'(QW - 1);
          end
        end
        CALC: begin
          op   <= {op[DW-3:0], 2'b00};
          root <= root_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - CW'(1);
          // Final remainder is bounded by 2*root, so RW bits always suffice.
          if (cnt == '0) begin
            Q         <= root_nxt;
            remainder <= rem_nxt[RW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
